nsc_ring_sequencer: RTL

Parametrised timing-state generator for the NSC control unit, the successor to the fixed 8-bit machine's ring counter. It produces a one-hot T-state ring of configurable length and lets the instruction decoder end an instruction's execute phase early. It adds halt-at-boundary, single-step mode and a retired-instruction counter. It sits between the clock and the control-word decoder, which consumes `t_state`/`t_index` to sequence fetch and execute micro-operations.

---
 rtl/nsc_pkg.sv | 14 +
 rtl/nsc_ring_sequencer_if.sv | 25 ++
 rtl/nsc_edge_detect.sv | 16 +
 rtl/nsc_ring_sequencer.sv | 61 ++++++
 4 files changed

// File: rtl/nsc_pkg.sv
// nsc_pkg: shared constants, index typedef and helpers for the NSC control unit
package nsc_pkg;
    localparam int NSC_T_STATES_DEF = 6;
    localparam int NSC_FETCH_STATES_DEF = 3;

    function automatic int nsc_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef logic [nsc_clog2(NSC_T_STATES_DEF)-1:0] nsc_tidx_t;
    typedef enum logic {RUN, HALT} nsc_run_e;
endpackage

// File: rtl/nsc_ring_sequencer_if.sv
// nsc_ring_sequencer_if: decoder-facing control and timing signals of the ring sequencer
interface nsc_ring_sequencer_if import nsc_pkg::*; #(
    parameter int T_STATES = NSC_T_STATES_DEF,
    parameter int CNT_W = 16
);
    logic end_cycle;
    logic halt;
    logic step_mode;
    logic step;
    logic [T_STATES-1:0] t_state;
    logic [nsc_clog2(T_STATES)-1:0] t_index;
    logic fetch;
    logic cycle_done;
    logic halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input end_cycle, halt, step_mode, step,
        output t_state, t_index, fetch, cycle_done, halted, instr_count
    );
    modport slave (
        output end_cycle, halt, step_mode, step,
        input t_state, t_index, fetch, cycle_done, halted, instr_count
    );
endinterface

// File: rtl/nsc_edge_detect.sv
// nsc_edge_detect: rising-edge detector for front-panel style inputs
module nsc_edge_detect (
    input logic clk,
    input logic rst,
    input logic d_i,
    output logic rise_o
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/nsc_ring_sequencer.sv
// nsc_ring_sequencer: one-hot T-state ring with early end, halt-at-boundary,
// single-step and a retired-instruction counter
module nsc_ring_sequencer import nsc_pkg::*; #(
    parameter int T_STATES = NSC_T_STATES_DEF,
    parameter int FETCH_STATES = NSC_FETCH_STATES_DEF,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset_ring,
    nsc_ring_sequencer_if.master bus
);
    localparam int IW = nsc_clog2(T_STATES);
    typedef logic [IW-1:0] idx_t;

    idx_t idx_q, idx_d;
    nsc_run_e state_q, state_d;
    logic halt_pend_q;
    logic cycle_done_q;
    logic [CNT_W-1:0] cnt_q;
    logic step_rise, adv, last, wrap;

    nsc_edge_detect u_step (
        .clk(clk),
        .rst(reset_ring),
        .d_i(bus.step),
        .rise_o(step_rise)
    );

    assign bus.fetch = idx_q < idx_t'(FETCH_STATES);
    assign bus.t_state = T_STATES'(1) << idx_q;

    // Indices past the last T-state count as last so the ring recovers to T0.
    always_comb begin
        adv = (state_q == RUN) && (!bus.step_mode || step_rise);
        last = (idx_q >= idx_t'(T_STATES-1)) || (bus.end_cycle && !bus.fetch);
        wrap = adv && last;
        idx_d = !adv ? idx_q : last ? '0 : idx_q + idx_t'(1);
        state_d = (wrap && (halt_pend_q || bus.halt)) ? HALT : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset_ring) begin
            idx_q <= '0;
            state_q <= RUN;
            halt_pend_q <= 1'b0;
            cycle_done_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            state_q <= state_d;
            halt_pend_q <= halt_pend_q | bus.halt;
            cycle_done_q <= wrap;
            cnt_q <= cnt_q + CNT_W'(wrap);
        end
    end

    assign bus.t_index = idx_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.halted = (state_q == HALT);
    assign bus.instr_count = cnt_q;
endmodule
